ins_buf: RTL and testbench

INS_BUF -- requirements
Module: ins_buf

---
 rtl/ins_buf.sv | 97 +++++++++
 tb/tb_ins_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ins_buf.sv
// ins_buf -- in-order instruction buffer between fetch and decode.
//
// A DEPTH-entry FIFO with a write pointer, a read pointer and an occupancy
// counter. The head entry is presented on out_ins while the buffer holds at
// least one word. Otherwise out_ins carries the NOP encoding. A flush discards
// every stored entry, for example on a branch or exception redirect.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset (pointers and count only)
//   in_valid   in   producer offers in_ins this cycle
//   in_ins     in   [WIDTH] instruction word from fetch
//   in_ready   out  buffer accepts a word this cycle (not full)
//   out_valid  out  out_ins holds a valid head entry (not empty)
//   out_ins    out  [WIDTH] oldest entry, or NOP when empty
//   out_ready  in   consumer takes the head this cycle
//   flush      in   drop all entries; wins over push and pop
//   count      out  [$clog2(DEPTH)+1] number of valid entries, 0..DEPTH
module ins_buf #(
  parameter int unsigned       WIDTH = 32,
  parameter int unsigned       DEPTH = 4,
  parameter logic [WIDTH-1:0]  NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_ins,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_ins,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push, pop;

  // Handshake signals come from registered state only. A pop on a full
  // buffer does not open a slot until the next cycle.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // No write-to-read bypass: a word pushed into an empty buffer shows up
  // one cycle after acceptance.
  assign out_ins = out_valid ? mem_q[rd_ptr_q] : NOP;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared. Writes are also gated by rst_n so that no
  // push lands on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (push && rst_n) mem_q[wr_ptr_q] <= in_ins;
  end

endmodule

// File: tb/tb_ins_buf.sv
module tb_ins_buf;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOPW  = 32'h00000013;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [WIDTH-1:0]  in_ins;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_ins;
  logic              out_ready;
  logic              flush;
  logic [2:0]        count;

  ins_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ins    (in_ins),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ins   (out_ins),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid  = iv;
    in_ins    = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Directed vectors: inputs applied for one edge, expected state after it.
  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        ordy;
    logic        fl;
    int unsigned cnt;
    logic [31:0] eins;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl,
                      input int unsigned cnt, input logic [31:0] eins, input logic erdy);
    vec_t v;
    v.iv = iv; v.ins = ins; v.ordy = ordy; v.fl = fl;
    v.cnt = cnt; v.eins = eins; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  // Reference model: a queue of stored words, updated from the buffer rules.
  logic [31:0] mq[$];

  task automatic model_edge(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    bit full, do_pop, do_push;
    if (fl) begin
      mq.delete();
    end else begin
      full    = (mq.size() == DEPTH);
      do_pop  = (mq.size() != 0) && ordy;
      do_push = iv && !full;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(ins);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".out_ins"},   out_ins,        (mq.size() != 0) ? mq[0] : NOPW);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("rst.count",     32'(count),     32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_ins",   out_ins,        NOPW);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    repeat (2) tick();
    rst_n = 1'b1;

    // Fill, overflow attempt, drain with wrap, hold, pop-on-empty.
    addv(1, 32'h11, 0, 0, 1, 32'h11, 1);
    addv(1, 32'h22, 0, 0, 2, 32'h11, 1);
    addv(1, 32'h33, 0, 0, 3, 32'h11, 1);
    addv(1, 32'h44, 0, 0, 4, 32'h11, 0);
    addv(1, 32'h55, 0, 0, 4, 32'h11, 0);
    addv(0, 32'h00, 1, 0, 3, 32'h22, 1);
    addv(0, 32'h00, 1, 0, 2, 32'h33, 1);
    addv(1, 32'h66, 0, 0, 3, 32'h33, 1);
    addv(1, 32'h77, 0, 0, 4, 32'h33, 0);
    addv(0, 32'h00, 1, 0, 3, 32'h44, 1);
    addv(0, 32'h00, 1, 0, 2, 32'h66, 1);
    addv(0, 32'hFF, 0, 0, 2, 32'h66, 1);
    addv(0, 32'h00, 1, 0, 1, 32'h77, 1);
    addv(0, 32'h00, 1, 0, 0, NOPW,   1);
    addv(0, 32'h00, 1, 0, 0, NOPW,   1);
    // Simultaneous push/pop, and full + pop + push rejected.
    addv(1, 32'hA0, 0, 0, 1, 32'hA0, 1);
    addv(1, 32'hA1, 0, 0, 2, 32'hA0, 1);
    addv(1, 32'hA2, 1, 0, 2, 32'hA1, 1);
    addv(1, 32'hA3, 0, 0, 3, 32'hA1, 1);
    addv(1, 32'hA4, 0, 0, 4, 32'hA1, 0);
    addv(1, 32'hA5, 1, 0, 3, 32'hA2, 1);
    // Flush priority, then a fresh push.
    addv(1, 32'hBB, 1, 1, 0, NOPW,   1);
    addv(1, 32'hCC, 0, 0, 1, 32'hCC, 1);
    addv(0, 32'h00, 0, 1, 0, NOPW,   1);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
      tick();
      check($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].cnt));
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].cnt != 0));
      check($sformatf("v%0d.out_ins", i),   out_ins,        vecs[i].eins);
      check($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].erdy));
    end

    // Empty latency: no bypass in the acceptance cycle.
    drive(1'b1, 32'hDD, 1'b0, 1'b0);
    #1;
    check("lat.same_valid", 32'(out_valid), 32'd0);
    check("lat.same_ins",   out_ins,        NOPW);
    tick();
    check("lat.next_valid", 32'(out_valid), 32'd1);
    check("lat.next_ins",   out_ins,        32'hDD);

    // Mid-operation reset: async clear, no push while held, push right after.
    drive(1'b1, 32'hDE, 1'b0, 1'b0);
    tick();
    check("mid.pre_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid.count",     32'(count),     32'd0);
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.out_ins",   out_ins,        NOPW);
    check("mid.in_ready",  32'(in_ready),  32'd1);
    tick();
    check("mid.held_count", 32'(count), 32'd0);
    #2 rst_n = 1'b1;
    drive(1'b1, 32'hEE, 1'b0, 1'b0);
    tick();
    check("mid.first_count", 32'(count), 32'd1);
    check("mid.first_ins",   out_ins,    32'hEE);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    check("mid.flush_count", 32'(count), 32'd0);

    // Randomized traffic against the queue model.
    mq.delete();
    for (int unsigned c = 0; c < 3000; c++) begin
      logic        iv, ordy, fl;
      logic [31:0] ins;
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 39) == 0);
      ins  = $urandom;
      drive(iv, ins, ordy, fl);
      model_edge(iv, ins, ordy, fl);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
